// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the single-port memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Memory owner as reported on grant_id
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_LDR  = 2'b10
    } grant_e;

    // Supported memory read latency window
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // True when a read latency fits the 2-bit WAIT counter
    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: favours the requester that did not win last time.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic pick_valid,
    output logic pick
);

    // pick=0 selects a, pick=1 selects b; last=1 means b won the previous grant
    always_comb begin
        pick_valid = req_a | req_b;
        pick       = req_b & (~req_a | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU control unit and the program loader.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        grant_id
);

    // Out-of-range latencies fall back to a single WAIT cycle
    localparam bit         RD_LAT_OK = rd_lat_legal(RD_LAT);
    localparam logic [1:0] CNT_LOAD  = RD_LAT_OK ? 2'(RD_LAT) : 2'd1;

    state_e              state_q, state_d;
    grant_e              grant_q, grant_d;
    logic                last_ldr_q, last_ldr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ldr_ack_q, ldr_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic                busy_q, busy_d;
    logic                pick_valid;
    logic                pick_ldr;

    // CPU only competes when boot mode is off
    rr_pick2 u_pick (
        .req_a      (cpu_req & ~boot_en),
        .req_b      (ldr_req),
        .last       (last_ldr_q),
        .pick_valid (pick_valid),
        .pick       (pick_ldr)
    );

    // Next-state logic: memory strobes are staged so they show up in the ISSUE cycle
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_ldr_d  = last_ldr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;

        case (state_q)
            IDLE: begin
                grant_d = GNT_NONE;
                if (pick_valid) begin
                    state_d     = ISSUE;
                    last_ldr_d  = pick_ldr;
                    grant_d     = pick_ldr ? GNT_LDR : GNT_CPU;
                    we_d        = pick_ldr ? ldr_we    : cpu_we;
                    addr_d      = pick_ldr ? ldr_addr  : cpu_addr;
                    wdata_d     = pick_ldr ? ldr_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    mem_addr_d  = addr_d;
                    mem_wdata_d = wdata_d;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d   = RESP;
                    cpu_ack_d = (grant_q == GNT_CPU);
                    ldr_ack_d = (grant_q == GNT_LDR);
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = RESP;
                    if (grant_q == GNT_CPU) begin
                        cpu_rdata_d = mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end
                    if (grant_q == GNT_LDR) begin
                        ldr_rdata_d = mem_rdata;
                        ldr_ack_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight access without an ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            last_ldr_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_ldr_q  <= last_ldr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Stall is combinational so the CPU freezes in the same cycle it raises a request
    always_comb begin
        cpu_stall = boot_en | (busy_q & (grant_q != GNT_CPU)) | (cpu_req & ~cpu_ack_q);
    end

    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RD_LAT=1 instance for arbitration tests, a RD_LAT=3 instance for latency.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        boot_en;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ldr_req, ldr_we;
    logic [9:0]  ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_ack;
    logic [31:0] ldr_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  grant_id;

    logic        d3_boot_en;
    logic        d3_cpu_req, d3_cpu_we;
    logic [9:0]  d3_cpu_addr;
    logic [31:0] d3_cpu_wdata;
    logic        d3_cpu_ack;
    logic [31:0] d3_cpu_rdata;
    logic        d3_cpu_stall;
    logic        d3_ldr_req, d3_ldr_we;
    logic [9:0]  d3_ldr_addr;
    logic [31:0] d3_ldr_wdata;
    logic        d3_ldr_ack;
    logic [31:0] d3_ldr_rdata;
    logic        d3_mem_en, d3_mem_we;
    logic [9:0]  d3_mem_addr;
    logic [31:0] d3_mem_wdata;
    logic [31:0] d3_mem_rdata;
    logic        d3_busy;
    logic [1:0]  d3_grant_id;

    int compared   = 0;
    int mismatched = 0;
    int memEnCount = 0;

    typedef struct {
        logic [1:0]  gnt;
        bit          isRead;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbQ[$];

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .boot_en(boot_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .boot_en(d3_boot_en),
        .cpu_req(d3_cpu_req), .cpu_we(d3_cpu_we), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
        .cpu_ack(d3_cpu_ack), .cpu_rdata(d3_cpu_rdata), .cpu_stall(d3_cpu_stall),
        .ldr_req(d3_ldr_req), .ldr_we(d3_ldr_we), .ldr_addr(d3_ldr_addr), .ldr_wdata(d3_ldr_wdata),
        .ldr_ack(d3_ldr_ack), .ldr_rdata(d3_ldr_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_rdata(d3_mem_rdata), .busy(d3_busy), .grant_id(d3_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: addresses 5 and 7 are fixed ROM words, everything else is RAM
    logic [31:0] memArr [0:1023];
    logic        rdValid1;
    logic [31:0] rdData1;
    logic [2:0]  rdV3;
    logic [31:0] rdD3 [0:2];

    function automatic logic [31:0] readWord(input logic [9:0] a);
        if (a == 10'd5) return 32'hDEAD_BEEF;
        if (a == 10'd7) return 32'hCAFE_F00D;
        return memArr[a];
    endfunction

    // RD_LAT=1 memory: write on strobe, read data valid for one cycle after the strobe
    always @(posedge clk) begin
        if (mem_en && mem_we) memArr[mem_addr] <= mem_wdata;
        rdValid1 <= mem_en && !mem_we;
        rdData1  <= readWord(mem_addr);
        if (mem_en) memEnCount <= memEnCount + 1;
    end
    assign mem_rdata = rdValid1 ? rdData1 : 32'h0BAD_F00D;

    // RD_LAT=3 memory: read data valid only in the third cycle after the strobe
    always @(posedge clk) begin
        rdV3    <= {rdV3[1:0], d3_mem_en && !d3_mem_we};
        rdD3[0] <= readWord(d3_mem_addr);
        rdD3[1] <= rdD3[0];
        rdD3[2] <= rdD3[1];
    end
    assign d3_mem_rdata = rdV3[2] ? rdD3[2] : 32'h0BAD_F00D;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit toLdr, input logic req, input logic we,
                                 input logic [9:0] addr, input logic [31:0] wdata);
        if (toLdr) begin
            ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic sbPush(input logic [1:0] gnt, input bit isRead, input logic [31:0] rdata);
        exp_t e;
        e.gnt = gnt; e.isRead = isRead; e.rdata = rdata;
        sbQ.push_back(e);
    endtask

    // Wait (bounded) for the next ack, then pop the scoreboard and compare owner, latency, data
    task automatic waitAck(input string tag, input int expTicks);
        int   ticks;
        bit   seen;
        exp_t e;
        ticks = 0;
        seen  = 0;
        while (!seen && ticks < 20) begin
            tick();
            ticks++;
            if (cpu_ack || ldr_ack) seen = 1;
        end
        checkOutput({tag, "_ack_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        checkOutput({tag, "_latency"}, 64'(ticks), 64'(expTicks));
        checkOutput({tag, "_sb_nonempty"}, 64'(sbQ.size() != 0), 64'd1);
        if (sbQ.size() == 0) return;
        e = sbQ.pop_front();
        checkOutput({tag, "_ack_owner"}, {62'd0, ldr_ack, cpu_ack}, {62'd0, e.gnt});
        if (e.isRead) begin
            if (e.gnt == GNT_CPU) checkOutput({tag, "_cpu_rdata"}, cpu_rdata, e.rdata);
            else                  checkOutput({tag, "_ldr_rdata"}, ldr_rdata, e.rdata);
        end
    endtask

    // Hard time limit so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        reset = 1'b0; boot_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 10'h010, 32'hA5A5_0001);
        d3_boot_en = 1'b0; d3_cpu_req = 1'b0; d3_cpu_we = 1'b0; d3_cpu_addr = '0; d3_cpu_wdata = '0;
        d3_ldr_req = 1'b0; d3_ldr_we = 1'b0; d3_ldr_addr = '0; d3_ldr_wdata = '0;

        // Reset held with a pending CPU write
        tick(); tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_acks", {cpu_ack, ldr_ack}, 0);
        checkOutput("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        checkOutput("rst_stall", cpu_stall, 1);
        checkOutput("rst_d3_busy", d3_busy, 0);

        // Release: CPU write issues next cycle, acks two cycles after the sampling cycle
        reset = 1'b1;
        sbPush(GNT_CPU, 1'b0, 32'd0);
        tick();
        checkOutput("wr_issue_en", mem_en, 1);
        checkOutput("wr_issue_we", mem_we, 1);
        checkOutput("wr_issue_addr", mem_addr, 10'h010);
        checkOutput("wr_issue_wdata", mem_wdata, 32'hA5A5_0001);
        checkOutput("wr_issue_grant", grant_id, GNT_CPU);
        checkOutput("wr_issue_busy", busy, 1);
        waitAck("rst_wr", 1);
        checkOutput("wr_resp_wdata", mem_wdata, 0);
        cpu_req = 1'b0;
        tick();
        checkOutput("wr_after_ack", cpu_ack, 0);
        checkOutput("wr_after_grant", grant_id, 0);
        checkOutput("wr_after_busy", busy, 0);
        checkOutput("idle_stall", cpu_stall, 0);

        // CPU read from the ROM word
        applyStimulus(1'b0, 1'b1, 1'b0, 10'h005, 32'd0);
        sbPush(GNT_CPU, 1'b1, 32'hDEAD_BEEF);
        tick();
        checkOutput("rd_issue_en", mem_en, 1);
        checkOutput("rd_issue_addr", mem_addr, 10'h005);
        checkOutput("rd_issue_we", mem_we, 0);
        waitAck("cpu_rd", 2);
        cpu_req = 1'b0;
        tick();
        checkOutput("rd_ack_pulse", cpu_ack, 0);
        checkOutput("rd_cpu_hold", cpu_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_ldr_untouched", ldr_rdata, 0);

        // Loader reads back the CPU's first write
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h010, 32'd0);
        sbPush(GNT_LDR, 1'b1, 32'hA5A5_0001);
        waitAck("ldr_rd", 3);
        ldr_req = 1'b0;
        tick();
        checkOutput("ldr_rd_cpu_untouched", cpu_rdata, 32'hDEAD_BEEF);

        // Contention: both held for four transactions, pointer alternates
        applyStimulus(1'b0, 1'b1, 1'b1, 10'h020, 32'h0000_C0C0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h030, 32'h0000_D0D0);
        memEnCount = 0;
        sbPush(GNT_CPU, 1'b0, 32'd0);
        sbPush(GNT_LDR, 1'b0, 32'd0);
        sbPush(GNT_CPU, 1'b0, 32'd0);
        sbPush(GNT_LDR, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            waitAck($sformatf("cont%0d", k), (k == 0) ? 2 : 3);
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
        checkOutput("cont_mem_en_pulses", 64'(memEnCount), 64'd4);
        checkOutput("cont_mem_20", readWord(10'h020), 32'h0000_C0C0);
        checkOutput("cont_mem_30", readWord(10'h030), 32'h0000_D0D0);

        // Boot mode: only the loader is served, CPU stays stalled
        boot_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 10'h040, 32'h0000_0099);
        #1;
        checkOutput("boot_stall_idle", cpu_stall, 1);
        ldr_req = 1'b1; ldr_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ldr_addr  = 10'(i);
            ldr_wdata = 32'h11 + 32'(i);
            sbPush(GNT_LDR, 1'b0, 32'd0);
            waitAck($sformatf("boot_ldr%0d", i), (i == 0) ? 2 : 3);
            checkOutput($sformatf("boot_stall%0d", i), cpu_stall, 1);
        end
        ldr_req = 1'b0;
        boot_en = 1'b0;
        sbPush(GNT_CPU, 1'b0, 32'd0);
        waitAck("boot_exit_cpu", 3);
        cpu_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("boot_mem%0d", i), readWord(10'(i)), 32'h11 + 32'(i));
        end
        checkOutput("boot_mem_40", readWord(10'h040), 32'h0000_0099);

        // Loader read: address changes in ISSUE, request drops in WAIT
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h002, 32'd0);
        sbPush(GNT_LDR, 1'b1, 32'h13);
        tick();
        checkOutput("mid_issue_addr", mem_addr, 10'h002);
        ldr_addr = 10'h3FF;
        tick();
        checkOutput("mid_wait_en", mem_en, 0);
        checkOutput("mid_wait_busy", busy, 1);
        checkOutput("mid_wait_addr", mem_addr, 0);
        ldr_req = 1'b0;
        waitAck("mid_ldr", 1);
        tick();
        checkOutput("mid_ack_pulse", ldr_ack, 0);

        // Reset in WAIT abandons the CPU read with no ack
        applyStimulus(1'b0, 1'b1, 1'b0, 10'h003, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        tick();
        checkOutput("rstw_ack", {cpu_ack, ldr_ack}, 0);
        checkOutput("rstw_busy", busy, 0);
        checkOutput("rstw_grant", grant_id, 0);
        checkOutput("rstw_mem_en", mem_en, 0);
        checkOutput("rstw_rdata", {cpu_rdata, ldr_rdata}, 0);
        reset = 1'b1;
        tick(); tick();
        checkOutput("rstw_no_late_ack", {cpu_ack, ldr_ack}, 0);

        // After reset the CPU wins the first tie again
        applyStimulus(1'b0, 1'b1, 1'b1, 10'h050, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h051, 32'h2);
        sbPush(GNT_CPU, 1'b0, 32'd0);
        sbPush(GNT_LDR, 1'b0, 32'd0);
        waitAck("post_rst0", 2);
        waitAck("post_rst1", 3);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();

        // RD_LAT=3 instance: three WAIT cycles, ack five cycles after sampling
        d3_cpu_req = 1'b1; d3_cpu_we = 1'b0; d3_cpu_addr = 10'h007;
        tick();
        checkOutput("l3_issue_en", d3_mem_en, 1);
        checkOutput("l3_issue_addr", d3_mem_addr, 10'h007);
        checkOutput("l3_issue_we", d3_mem_we, 0);
        checkOutput("l3_issue_wdata", d3_mem_wdata, 0);
        tick();
        checkOutput("l3_wait1_en", d3_mem_en, 0);
        checkOutput("l3_wait1_busy", d3_busy, 1);
        tick();
        checkOutput("l3_wait2_ack", d3_cpu_ack, 0);
        tick();
        checkOutput("l3_wait3_ack", d3_cpu_ack, 0);
        checkOutput("l3_wait3_rdata", d3_cpu_rdata, 0);
        tick();
        checkOutput("l3_resp_ack", d3_cpu_ack, 1);
        checkOutput("l3_resp_rdata", d3_cpu_rdata, 32'hCAFE_F00D);
        checkOutput("l3_resp_grant", d3_grant_id, GNT_CPU);
        checkOutput("l3_resp_ldr", {d3_ldr_ack, d3_ldr_rdata}, 0);
        d3_cpu_req = 1'b0;
        tick();
        checkOutput("l3_after_ack", d3_cpu_ack, 0);
        checkOutput("l3_after_hold", d3_cpu_rdata, 32'hCAFE_F00D);
        checkOutput("l3_after_busy", d3_busy, 0);
        checkOutput("l3_after_stall", d3_cpu_stall, 0);

        checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the processor control unit (fetch/load/store) and the external program loader.
- Sits between both requesters and the shared memory.
- Serialises accesses, returns read data and a one-cycle ack to the owning requester.
- Stalls the CPU while boot mode is active or the loader owns the memory.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 32, data word width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- boot_en  input  1  boot mode; while 1, only the loader is eligible.
- cpu_req  input  1  CPU request; held until cpu_ack.
- cpu_we  input  1  CPU write enable (1 = write).
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse to CPU.
- cpu_rdata  output  DATA_W  CPU read data; valid with cpu_ack, held until next CPU read completes.
- cpu_stall  output  1  CPU must freeze its control FSM.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/ADDR_W/DATA_W  loader request set; same semantics as CPU.
- ldr_ack  output  1  one-cycle completion pulse to loader.
- ldr_rdata  output  DATA_W  loader read data; same semantics as cpu_rdata.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after the mem_en cycle.
- busy  output  1  transaction in progress (state != IDLE).
- grant_id  output  2  owner: 00 none, 01 CPU, 10 loader.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; all outputs 0 (acks, rdata, mem_*, busy, grant_id).
  - last_grant=LDR, so the CPU wins the first tie.
  - An in-flight transaction is abandoned with no ack.
- FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered except cpu_stall.
- IDLE: pick a winner.
  - Eligible: ldr_req; cpu_req only when boot_en=0.
  - One eligible: that one wins. Both eligible: the requester not equal to last_grant wins (2-way round-robin).
  - On a win: latch we/addr/wdata, set grant_id and last_grant, go to ISSUE. No eligible request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_we/mem_addr/mem_wdata driven from latched values.
  - Write: go to RESP. Read: load counter with RD_LAT, go to WAIT.
- WAIT:
  - mem_en=0; decrement counter each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into the owner's rdata register; go to RESP.
  - WAIT lasts exactly RD_LAT cycles.
- RESP (1 cycle): owner's ack=1, then go to IDLE; grant_id returns to 00 in IDLE.
- Latency from the IDLE cycle that samples req:
  - write ack in cycle +2;
  - read ack in cycle +2+RD_LAT (RD_LAT=1 gives +3).
- Back-to-back: minimum gap between acks is 3 cycles for writes, 3+RD_LAT for reads.
  - A requester that keeps req high in the IDLE cycle after its ack is treated as a new request.
  - The round-robin pointer alternates under contention.
- Requester inputs are latched at IDLE→ISSUE. Changes during ISSUE/WAIT/RESP are ignored. If req drops mid-transaction, the transaction still completes and ack still pulses.
- boot_en changes take effect only at the next IDLE arbitration; an in-progress CPU transaction completes normally.
- cpu_stall is combinational: boot_en OR (busy AND grant_id != 01) OR (cpu_req AND NOT cpu_ack).
- The non-owner's rdata register is never modified.
- Write data never appears on mem_wdata outside ISSUE (held 0 otherwise).

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11;
  - grant ids GNT_NONE/GNT_CPU/GNT_LDR;
  - RD_LAT legality check constant.
- Sub-module rr_pick2: inputs req_a, req_b, last; outputs pick_valid, pick. Purely combinational 2-way round-robin.
- The top level holds the FSM, latches, counter and rdata registers.

Test Plan:
- Reset: hold reset=0 for 2 cycles with cpu_req=1 → all outputs 0, busy=0, grant_id=00; release → CPU write granted; mem_en=1 one cycle later; cpu_ack exactly 2 cycles after the first IDLE sample.
- CPU read: cpu_req, cpu_addr=0x005, mem returns 0xDEADBEEF, RD_LAT=1 → mem_en pulse with mem_addr=0x005; cpu_ack 3 cycles after sampling; cpu_rdata=0xDEADBEEF held afterwards; ldr_rdata unchanged.
- Contention: cpu_req and ldr_req both held high for 4 transactions → grants CPU, LDR, CPU, LDR; no overlap of mem_en; each ack pulses once per grant.
- Boot mode: boot_en=1, loader writes 0x11..0x14 to addresses 0..3 while cpu_req=1 → only the loader granted; cpu_stall=1 throughout. Drop boot_en → CPU granted at the next IDLE.
- Mid-transaction events:
  - Drop ldr_req during WAIT → ldr_ack still pulses.
  - Change ldr_addr during ISSUE → mem_addr unchanged.
  - Assert reset during WAIT → no ack, state IDLE, mem_en=0 next cycle.
- RD_LAT=3: CPU read → WAIT 3 cycles; ack 5 cycles after the sampling IDLE cycle; data captured on the third WAIT cycle.
